// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the MIPS fetch path and the load/store path.
// Define ARB_STATS_EN to compile in the icnt/dcnt/stallcnt statistics ports and counters.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [31:0]       iaddr,
    output logic              iwait,
    output logic [31:0]       iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [31:0]       daddr,
    input  logic [31:0]       dstore,
    output logic              dwait,
    output logic [31:0]       dload,
    input  logic              halt,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [31:0]       ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic              ram_ready,
    output logic              err
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  icnt,
    output logic [CNT_W-1:0]  dcnt,
    output logic [CNT_W-1:0]  stallcnt
`endif
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, ERR} state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be in 1..65535");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mem_arbiter: CNT_W must be at least 1");
    end

    state_t      state;
    logic [15:0] tcnt;
    logic        d_req;
    logic        i_done;
    logic        d_done;
    logic        timed_out;

    assign d_req     = dREN || dWEN;
    assign i_done    = (state == IGRANT) && iREN && ram_ready;
    assign d_done    = (state == DGRANT) && d_req && ram_ready;
    // The stall that brings the count up to TIMEOUT is the one that faults.
    assign timed_out = (tcnt == 16'(TIMEOUT - 1));

    // NOTE: synchronous reset lives inside the clocked block, and all state uses <=.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (dREN && dWEN)       state <= ERR;
                    else if (d_req)         state <= DGRANT;
                    else if (iREN && !halt) state <= IGRANT;
                end
                IGRANT: begin
                    if (!iREN || ram_ready) state <= IDLE;
                    else if (timed_out)     state <= ERR;
                    else                    tcnt  <= tcnt + 16'd1;
                end
                DGRANT: begin
                    if (!d_req || ram_ready) state <= IDLE;
                    else if (timed_out)      state <= ERR;
                    else                     tcnt  <= tcnt + 16'd1;
                end
                default: state <= ERR;
            endcase
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign err   = (state == ERR);
    assign iwait = (iREN && !((state == IGRANT) && ram_ready)) || err;
    assign dwait = (d_req && !((state == DGRANT) && ram_ready)) || err;
    assign iload = i_done ? ramload : '0;
    assign dload = (d_done && dREN) ? ramload : '0;

`ifdef ARB_STATS_EN
    // Saturating counters: they stop at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            icnt     <= '0;
            dcnt     <= '0;
            stallcnt <= '0;
        end else begin
            if (i_done && icnt != '1)             icnt     <= icnt + CNT_W'(1);
            if (d_done && dcnt != '1)             dcnt     <= dcnt + CNT_W'(1);
            if (iwait && !halt && stallcnt != '1) stallcnt <= stallcnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences for halt, timeout, reset and illegal requests.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, halt, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_STATS_EN
    logic [2:0]  icnt, dcnt, stallcnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .halt(halt),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .err(err)
`ifdef ARB_STATS_EN
        , .icnt(icnt), .dcnt(dcnt), .stallcnt(stallcnt)
`endif
    );

    typedef struct {
        logic        i_ren;  logic [31:0] i_addr;
        logic        d_ren;  logic        d_wen;
        logic [31:0] d_addr; logic [31:0] d_store;
        logic        hlt;    logic [31:0] ld;     logic rdy;
        logic        e_iwait; logic [31:0] e_iload;
        logic        e_dwait; logic [31:0] e_dload;
        logic        e_rren;  logic        e_rwen;
        logic [31:0] e_raddr; logic [31:0] e_rstore;
    } vec_t;

    vec_t tv [26];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] ds, input logic h,
        input logic [31:0] ld, input logic rdy,
        input logic eiw, input logic [31:0] eil, input logic edw, input logic [31:0] edl,
        input logic err_, input logic ewe, input logic [31:0] ea, input logic [31:0] es);
        vec_t v;
        v.i_ren = ir; v.i_addr = ia; v.d_ren = dr; v.d_wen = dw;
        v.d_addr = da; v.d_store = ds; v.hlt = h; v.ld = ld; v.rdy = rdy;
        v.e_iwait = eiw; v.e_iload = eil; v.e_dwait = edw; v.e_dload = edl;
        v.e_rren = err_; v.e_rwen = ewe; v.e_raddr = ea; v.e_rstore = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic h,
                         input logic [31:0] ld, input logic rdy);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da;
        dstore = ds; halt = h; ramload = ld; ram_ready = rdy;
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_i = 0;
        int exp_d = 0;
        int exp_s = 0;

        // Fetch, conflict, store, abort, halt-in-grant and data-during-halt, one row per cycle.
        tv[0]  = mk(1,'h40,0,0,0,0,0,0,0,                       1,0,0,0,0,0,0,0);
        tv[1]  = mk(1,'h40,0,0,0,0,0,0,0,                       1,0,0,0,1,0,'h40,0);
        tv[2]  = mk(1,'h40,0,0,0,0,0,0,0,                       1,0,0,0,1,0,'h40,0);
        tv[3]  = mk(1,'h40,0,0,0,0,0,'h2002000A,1,              0,'h2002000A,0,0,1,0,'h40,0);
        tv[4]  = mk(0,0,0,0,0,0,0,'h2002000A,1,                 0,0,0,0,0,0,0,0);
        tv[5]  = mk(1,'h80,1,0,'h100,0,0,0,0,                   1,0,1,0,0,0,0,0);
        tv[6]  = mk(1,'h80,1,0,'h100,0,0,'h12345678,1,          1,0,0,'h12345678,1,0,'h100,0);
        tv[7]  = mk(1,'h80,0,0,'h100,0,0,0,0,                   1,0,0,0,0,0,0,0);
        tv[8]  = mk(1,'h80,0,0,0,0,0,'hCAFEF00D,1,              0,'hCAFEF00D,0,0,1,0,'h80,0);
        tv[9]  = mk(0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0);
        tv[10] = mk(0,0,0,1,'h200,'hDEADBEEF,0,0,0,             0,0,1,0,0,0,0,0);
        tv[11] = mk(0,0,0,1,'h200,'hDEADBEEF,0,'h55555555,1,    0,0,0,0,0,1,'h200,'hDEADBEEF);
        tv[12] = mk(0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0);
        tv[13] = mk(0,0,1,0,'h300,0,0,0,0,                      0,0,1,0,0,0,0,0);
        tv[14] = mk(0,0,1,0,'h300,0,0,0,0,                      0,0,1,0,1,0,'h300,0);
        tv[15] = mk(0,0,0,0,'h300,0,0,0,0,                      0,0,0,0,0,0,'h300,0);
        tv[16] = mk(1,'h44,0,0,'h300,0,0,0,0,                   1,0,0,0,0,0,0,0);
        tv[17] = mk(1,'h44,0,0,0,0,0,'h11,1,                    0,'h11,0,0,1,0,'h44,0);
        tv[18] = mk(1,'h48,0,0,0,0,0,0,0,                       1,0,0,0,0,0,0,0);
        tv[19] = mk(1,'h48,0,0,0,0,1,0,0,                       1,0,0,0,1,0,'h48,0);
        tv[20] = mk(1,'h48,0,0,0,0,1,'h22,1,                    0,'h22,0,0,1,0,'h48,0);
        tv[21] = mk(0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0);
        tv[22] = mk(1,'h4C,1,0,'h400,0,1,0,0,                   1,0,1,0,0,0,0,0);
        tv[23] = mk(1,'h4C,1,0,'h400,0,1,'h33,1,                1,0,0,'h33,1,0,'h400,0);
        tv[24] = mk(1,'h4C,0,0,0,0,1,0,0,                       1,0,0,0,0,0,0,0);
        tv[25] = mk(0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0);

        RST = 1'b1;
        drive(1,'h40,0,0,0,0,0,'hFFFFFFFF,1);
        repeat (2) @(negedge CLK);
        #1;
        check("reset iwait", iwait, 1);
        check("reset dwait", dwait, 0);
        check("reset err", err, 0);
        check("reset ramREN", ramREN, 0);
        check("reset ramaddr", ramaddr, 0);
        check("reset iload", iload, 0);
`ifdef ARB_STATS_EN
        check("reset icnt", icnt, 0);
        check("reset stallcnt", stallcnt, 0);
`endif
        RST = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive(tv[i].i_ren, tv[i].i_addr, tv[i].d_ren, tv[i].d_wen, tv[i].d_addr,
                  tv[i].d_store, tv[i].hlt, tv[i].ld, tv[i].rdy);
            #1;
            check($sformatf("v%0d iwait", i),    iwait,    tv[i].e_iwait);
            check($sformatf("v%0d iload", i),    iload,    tv[i].e_iload);
            check($sformatf("v%0d dwait", i),    dwait,    tv[i].e_dwait);
            check($sformatf("v%0d dload", i),    dload,    tv[i].e_dload);
            check($sformatf("v%0d ramREN", i),   ramREN,   tv[i].e_rren);
            check($sformatf("v%0d ramWEN", i),   ramWEN,   tv[i].e_rwen);
            check($sformatf("v%0d ramaddr", i),  ramaddr,  tv[i].e_raddr);
            check($sformatf("v%0d ramstore", i), ramstore, tv[i].e_rstore);
            check($sformatf("v%0d err", i),      err,      0);
            if (tv[i].i_ren && !tv[i].e_iwait) exp_i++;
            if ((tv[i].d_ren || tv[i].d_wen) && !tv[i].e_dwait) exp_d++;
            if (tv[i].e_iwait && !tv[i].hlt) exp_s++;
            @(negedge CLK);
        end

`ifdef ARB_STATS_EN
        #1;
        check("stats icnt", icnt, 32'(sat7(exp_i)));
        check("stats dcnt", dcnt, 32'(sat7(exp_d)));
        check("stats stallcnt", stallcnt, 32'(sat7(exp_s)));
        @(negedge CLK);
`endif

        // Halt holds a pending fetch in IDLE; releasing it grants on the next edge.
        drive(1,'h50,0,0,0,0,1,0,0);
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("halt%0d ramREN", k), ramREN, 0);
            check($sformatf("halt%0d iwait", k), iwait, 1);
            @(negedge CLK);
        end
        drive(1,'h50,0,0,0,0,0,0,0);
        #1;
        check("unhalt idle ramREN", ramREN, 0);
        check("unhalt idle iwait", iwait, 1);
        @(negedge CLK);
        drive(1,'h50,0,0,0,0,0,'h66,1);
        #1;
        check("unhalt grant ramREN", ramREN, 1);
        check("unhalt grant ramaddr", ramaddr, 'h50);
        check("unhalt grant iload", iload, 'h66);
        check("unhalt grant iwait", iwait, 0);
        @(negedge CLK);
        drive(0,0,0,0,0,0,0,0,0);
        @(negedge CLK);

        // Timeout: four granted cycles without ready, then ERR until reset.
        drive(0,0,1,0,'h600,0,0,0,0);
        #1;
        check("to idle dwait", dwait, 1);
        check("to idle ramREN", ramREN, 0);
        @(negedge CLK);
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("to grant%0d ramREN", k), ramREN, 1);
            check($sformatf("to grant%0d err", k), err, 0);
            check($sformatf("to grant%0d dwait", k), dwait, 1);
            @(negedge CLK);
        end
        #1;
        check("to err err", err, 1);
        check("to err ramREN", ramREN, 0);
        check("to err dwait", dwait, 1);
        check("to err iwait", iwait, 1);
        @(negedge CLK);
        drive(0,0,0,0,0,0,0,'h77,1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("err hold%0d err", k), err, 1);
            check($sformatf("err hold%0d iwait", k), iwait, 1);
            check($sformatf("err hold%0d dwait", k), dwait, 1);
            check($sformatf("err hold%0d ramREN", k), ramREN, 0);
            check($sformatf("err hold%0d dload", k), dload, 0);
            @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("post-err err", err, 0);
        check("post-err iwait", iwait, 0);
        check("post-err dwait", dwait, 0);

        // Reset in the middle of a fetch grant returns to IDLE.
        @(negedge CLK);
        drive(1,'h90,0,0,0,0,0,0,0);
        #1;
        check("midrst idle ramREN", ramREN, 0);
        @(negedge CLK);
        #1;
        check("midrst grant ramREN", ramREN, 1);
        check("midrst grant ramaddr", ramaddr, 'h90);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midrst after ramREN", ramREN, 0);
        check("midrst after ramaddr", ramaddr, 0);
        check("midrst after iwait", iwait, 1);
        drive(0,0,0,0,0,0,0,0,0);

        // Simultaneous read and write request is illegal.
        @(negedge CLK);
        drive(0,0,1,1,'h700,'h1,0,0,0);
        #1;
        check("illegal idle err", err, 0);
        check("illegal idle dwait", dwait, 1);
        @(negedge CLK);
        drive(0,0,0,0,0,0,0,0,1);
        #1;
        check("illegal err", err, 1);
        check("illegal dwait", dwait, 1);
        check("illegal ramREN", ramREN, 0);
        check("illegal ramWEN", ramWEN, 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("illegal cleared err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
